// File: rtl/setup_launch_pkg.sv
// setup_launch_pkg: shared types and defaults for the setup-edge launcher.
//   launch_state_e : launcher FSM states (idle, setup countdown, hold countdown)
//   DefaultW/CW    : default data/strobe width and cycle-count width
package setup_launch_pkg;

    localparam int unsigned DefaultW  = 2;
    localparam int unsigned DefaultCW = 4;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StHold
    } launch_state_e;

endpackage

// File: rtl/launch_cnt.sv
// launch_cnt: CW-bit loadable down-counter shared by the setup and hold phases.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : load load_val_i (has priority over decrement)
//   load_val_i    : value to load
//   dec_i         : decrement enable; saturates at zero
//   cnt_o, zero_o : current count and count == 0 flag
module launch_cnt
    import setup_launch_pkg::*;
#(
    parameter int unsigned CW = DefaultCW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          dec_i,
    output logic [CW-1:0] cnt_o,
    output logic          zero_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/setup_edge_launcher.sv
// setup_edge_launcher: drives a data vector, then after setup_cyc_i extra cycles raises an
// all-ones strobe for hold_cyc_i+1 cycles, then drops it with a one-cycle done pulse.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   start_i        : launch request, sampled only while ready_o = 1
//   data_in_i      : value launched onto d_out_o
//   setup_cyc_i    : extra cycles between data edge and strobe rise
//   hold_cyc_i     : extra cycles the strobe stays high
//   ready_o        : idle, accepting start_i
//   d_out_o        : launched data, held between launches
//   strb_out_o     : strobe vector, all bits move together
//   done_o         : one-cycle pulse in the cycle after the strobe falls
//   notifier_o     : toggles on a launch with setup_cyc_i < MIN_SETUP
// Build option: define SETUP_LAUNCH_NOTIFIER_EN to compile in the notifier; otherwise
// notifier_o is tied low and MIN_SETUP has no effect.
module setup_edge_launcher
    import setup_launch_pkg::*;
#(
    parameter int unsigned W         = DefaultW,
    parameter int unsigned CW        = DefaultCW,
    parameter int unsigned MIN_SETUP = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [W-1:0]  data_in_i,
    input  logic [CW-1:0] setup_cyc_i,
    input  logic [CW-1:0] hold_cyc_i,
    output logic          ready_o,
    output logic [W-1:0]  d_out_o,
    output logic [W-1:0]  strb_out_o,
    output logic          done_o,
    output logic          notifier_o
);

    launch_state_e state_q, state_d;

    logic [W-1:0]  d_q, strb_q;
    logic [CW-1:0] hold_q;
    logic          done_q;

    logic          accept;
    logic          strb_set, strb_clr;
    logic          cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0] cnt_load_val, cnt_val;

    launch_cnt #(
        .CW (CW)
    ) u_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt_val),
        .zero_o     (cnt_zero)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i)  state_d = StSetup;
            StSetup: if (cnt_zero) state_d = StHold;
            StHold:  if (cnt_zero) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs and datapath controls
    always_comb begin
        ready_o      = 1'b0;
        accept       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        strb_set     = 1'b0;
        strb_clr     = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready_o = 1'b1;
                if (start_i) begin
                    accept       = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = setup_cyc_i;
                end
            end
            StSetup: begin
                if (cnt_zero) begin
                    strb_set     = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = hold_q;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StHold: begin
                if (cnt_zero) begin
                    strb_clr = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_q    <= '0;
            hold_q <= '0;
            strb_q <= '0;
            done_q <= 1'b0;
        end else begin
            if (accept) begin
                d_q    <= data_in_i;
                hold_q <= hold_cyc_i;
            end
            if (strb_set) begin
                strb_q <= '1;
            end else if (strb_clr) begin
                strb_q <= '0;
            end
            done_q <= strb_clr;
        end
    end

    assign d_out_o    = d_q;
    assign strb_out_o = strb_q;
    assign done_o     = done_q;

`ifdef SETUP_LAUNCH_NOTIFIER_EN
    logic notif_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            notif_q <= 1'b0;
        end else if (accept && (32'(setup_cyc_i) < MIN_SETUP)) begin
            notif_q <= ~notif_q;
        end
    end

    assign notifier_o = notif_q;
`else
    // MIN_SETUP only matters when the notifier is compiled in
    logic unused_min_setup;
    assign unused_min_setup = ^MIN_SETUP;
    assign notifier_o       = 1'b0;
`endif

    // Count value is only observed through zero_o
    logic unused_cnt_val;
    assign unused_cnt_val = ^cnt_val;

endmodule

// File: tb/tb_setup_edge_launcher.sv
module tb_setup_edge_launcher;

    localparam int unsigned W  = 2;
    localparam int unsigned CW = 4;
`ifdef SETUP_LAUNCH_NOTIFIER_EN
    localparam bit NotifEn = 1'b1;
`else
    localparam bit NotifEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  data_in;
    logic [CW-1:0] setup_cyc, hold_cyc;
    logic          ready, done, notifier;
    logic [W-1:0]  d_out, strb_out;

    setup_edge_launcher #(
        .W         (W),
        .CW        (CW),
        .MIN_SETUP (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .data_in_i   (data_in),
        .setup_cyc_i (setup_cyc),
        .hold_cyc_i  (hold_cyc),
        .ready_o     (ready),
        .d_out_o     (d_out),
        .strb_out_o  (strb_out),
        .done_o      (done),
        .notifier_o  (notifier)
    );

    always #5 clk = ~clk;

    // {ready, d_out, strb_out, done}
    logic [5:0] obs;
    assign obs = {ready, d_out, strb_out, done};

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic          start;
        logic [W-1:0]  data;
        logic [CW-1:0] s;
        logic [CW-1:0] h;
        logic [5:0]    exp;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic st, input logic [1:0] d, input logic [3:0] s,
                                input logic [3:0] h, input logic r, input logic [1:0] ed,
                                input logic [1:0] es, input logic dn);
        vec_t v;
        v.start = st;
        v.data  = d;
        v.s     = s;
        v.h     = h;
        v.exp   = {r, ed, es, dn};
        return v;
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {rdy,d,strb,done}=%b want %b", name, act, exp);
        end
    endtask

    task automatic check_notif(input string name, input logic exp);
        n_vec++;
        if (notifier !== exp) begin
            n_err++;
            $display("FAIL %s: notifier got %b want %b", name, notifier, exp);
        end
    endtask

    task automatic launch(input logic [1:0] d, input logic [3:0] s, input logic [3:0] h);
        @(negedge clk);
        start     = 1'b1;
        data_in   = d;
        setup_cyc = s;
        hold_cyc  = h;
        @(posedge clk);
        #1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            @(posedge clk);
            #1;
            seen = done;
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s: done got 0 within 64 cycles want 1", name);
        end
    endtask

    initial begin
        // Basic S=0,H=0 launch
        vecs[0]  = mk(1, 2'b11, 0, 0, 0, 2'b11, 2'b00, 0);
        vecs[1]  = mk(0, 2'b11, 0, 0, 0, 2'b11, 2'b11, 0);
        vecs[2]  = mk(0, 2'b11, 0, 0, 1, 2'b11, 2'b00, 1);
        vecs[3]  = mk(0, 2'b11, 0, 0, 1, 2'b11, 2'b00, 0);
        // S=3,H=2; data_in changes after capture
        vecs[4]  = mk(1, 2'b10, 3, 2, 0, 2'b10, 2'b00, 0);
        vecs[5]  = mk(0, 2'b01, 0, 0, 0, 2'b10, 2'b00, 0);
        vecs[6]  = mk(0, 2'b01, 0, 0, 0, 2'b10, 2'b00, 0);
        vecs[7]  = mk(0, 2'b01, 0, 0, 0, 2'b10, 2'b00, 0);
        vecs[8]  = mk(0, 2'b01, 0, 0, 0, 2'b10, 2'b11, 0);
        vecs[9]  = mk(0, 2'b01, 0, 0, 0, 2'b10, 2'b11, 0);
        vecs[10] = mk(0, 2'b01, 0, 0, 0, 2'b10, 2'b11, 0);
        vecs[11] = mk(0, 2'b01, 0, 0, 1, 2'b10, 2'b00, 1);
        vecs[12] = mk(0, 2'b01, 0, 0, 1, 2'b10, 2'b00, 0);
        // start held high through a launch: ignored until the done cycle
        vecs[13] = mk(1, 2'b01, 1, 0, 0, 2'b01, 2'b00, 0);
        vecs[14] = mk(1, 2'b10, 0, 5, 0, 2'b01, 2'b00, 0);
        vecs[15] = mk(1, 2'b10, 0, 5, 0, 2'b01, 2'b11, 0);
        vecs[16] = mk(1, 2'b10, 0, 0, 1, 2'b01, 2'b00, 1);
        vecs[17] = mk(1, 2'b10, 0, 0, 0, 2'b10, 2'b00, 0);
        vecs[18] = mk(0, 2'b10, 0, 0, 0, 2'b10, 2'b11, 0);
        vecs[19] = mk(0, 2'b10, 0, 0, 1, 2'b10, 2'b00, 1);
        vecs[20] = mk(0, 2'b10, 0, 0, 1, 2'b10, 2'b00, 0);

        rst_n     = 1'b0;
        start     = 1'b0;
        data_in   = '0;
        setup_cyc = '0;
        hold_cyc  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", obs, 6'b1_00_00_0);
        check_notif("reset_notif", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            start     = vecs[i].start;
            data_in   = vecs[i].data;
            setup_cyc = vecs[i].s;
            hold_cyc  = vecs[i].h;
            @(posedge clk);
            #1;
            check($sformatf("vec[%0d]", i), obs, vecs[i].exp);
        end
        // Launches with S=0, S=1, S=0 each fall below MIN_SETUP=2
        check_notif("table_notif", NotifEn);

        // Maximum counts: no wrap
        @(negedge clk);
        start     = 1'b1;
        data_in   = 2'b01;
        setup_cyc = 4'd15;
        hold_cyc  = 4'd15;
        @(posedge clk);
        #1;
        check("max[0]", obs, 6'b0_01_00_0);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            logic [5:0] e;
            @(posedge clk);
            #1;
            e = {(k >= 32) ? 1'b1 : 1'b0, 2'b01, (k >= 16 && k < 32) ? 2'b11 : 2'b00,
                 (k == 32) ? 1'b1 : 1'b0};
            check($sformatf("max[%0d]", k), obs, e);
        end

        // Reset in HOLD aborts immediately, no done afterwards
        @(negedge clk);
        start     = 1'b1;
        data_in   = 2'b11;
        setup_cyc = 4'd0;
        hold_cyc  = 4'd5;
        @(posedge clk);
        #1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("abort_hold", obs, 6'b0_11_11_0);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_reset", obs, 6'b1_00_00_0);
        check_notif("abort_notif", 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("abort_idle[%0d]", k), obs, 6'b1_00_00_0);
        end

        // Under-margin notifier: S=1 toggles, S=2 leaves it alone
        launch(2'b10, 4'd1, 4'd0);
        check_notif("notif_s1", NotifEn);
        wait_done("notif_s1_done");
        launch(2'b01, 4'd2, 4'd0);
        check_notif("notif_s2", NotifEn);
        wait_done("notif_s2_done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/setup_edge_launcher.md
# setup_edge_launcher

Synchronous stimulus launcher for the setup-check bench: drives a data vector, then after a programmable number of clock cycles raises a strobe vector, holds it, and releases it. It is the driving end of the data/strobe pair that a `$setup(posedge d, posedge strobe, …)` checker observes. It gives benches a cycle-accurate way to place data edges before strobe edges, so timing checks can be exercised with known margins.

## Interface
Parameters:
- `W`, default 2, width of the data and strobe vectors.
- `CW`, default 4, width of the setup and hold cycle counts.
- `MIN_SETUP`, default 1, minimum legal `setup_cyc`. Used only when the notifier is compiled in.

Ports:
- `clk`  in  1  single clock; all state updates on its posedge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  launch request; sampled only when `ready`=1.
- `data_in`  in  W  value to drive onto `d_out`.
- `setup_cyc`  in  CW  extra cycles between the data edge and the strobe rise.
- `hold_cyc`  in  CW  extra cycles the strobe stays high.
- `ready`  out  1  high in IDLE; launcher accepts `start`.
- `d_out`  out  W  launched data; retained between launches.
- `strb_out`  out  W  strobe vector; all bits move together.
- `done`  out  1  one-cycle pulse, coincident with the strobe fall.
- `notifier`  out  1  toggles on an under-margin launch (see Configuration).

## Operation
- FSM states: IDLE, SETUP, HOLD.
- **IDLE:** `ready`=1.
  - On `start`=1, capture `data_in`, `setup_cyc` and `hold_cyc` at the same edge.
  - `d_out` <= `data_in` at that same edge.
  - Load the counter with `setup_cyc` and go to SETUP.
- **SETUP:** `ready`=0.
  - While the counter ≠ 0, decrement it.
  - When the counter = 0, set `strb_out` <= all ones, load the counter with the captured `hold_cyc`, and go to HOLD.
- **HOLD:** `ready`=0.
  - While the counter ≠ 0, decrement it.
  - When the counter = 0, set `strb_out` <= 0, `done` <= 1, and go to IDLE.
- `start` while `ready`=0 is ignored; it is neither queued nor able to corrupt the captured values.
- `data_in` changes after capture do not affect `d_out` until the next accepted launch.
- Counter arithmetic is unsigned, CW bits, and never wraps. The decrement is gated at 0.
- Maximum counts are `setup_cyc` = `hold_cyc` = 2^CW−1. They are legal and run to completion.

## Timing
- Let E0 be the edge that accepts `start`, and let S and H be the captured counts.
- `d_out` changes at E0.
- `strb_out` rises at E0+S+1. Strobe-after-data is therefore ≥1 cycle even when S=0.
- `strb_out` falls at E0+S+H+2. The strobe is high for H+1 cycles.
- `done` is high for exactly the cycle following E0+S+H+2.
- `ready` is high in that same cycle, so a launch can be accepted there. Back-to-back launches leave 0 idle cycles.
- Reset values while `rst_n`=0: `ready`=1, `d_out`=0, `strb_out`=0, `done`=0, `notifier`=0, state IDLE, counter 0.
- Reset asserted mid-launch clears everything asynchronously; no `done` is produced for the aborted launch.

## Configuration
- Macro: `SETUP_LAUNCH_NOTIFIER_EN`.
- **Defined:** at an accepted launch with `setup_cyc` < `MIN_SETUP`, `notifier` toggles at E0. The launch still runs normally.
- **Not defined:** `notifier` is tied to 0, the comparison logic is absent, and `MIN_SETUP` is unused.

## Structure
- Package `setup_launch_pkg`:
  - state enum `launch_state_e` {IDLE, SETUP, HOLD};
  - localparam defaults for W and CW.
- One sub-module, `launch_cnt`:
  - CW-bit loadable down-counter;
  - inputs: load, load value, decrement enable;
  - outputs: count and `zero`.
  - The FSM instantiates it once and reuses it for both the setup and hold phases.

## Test plan
- Reset, then `start` with `data_in`=2'b11, S=0, H=0: `d_out`=11 at E0, strobe high only between E0+1 and E0+2, `done` in the cycle after E0+2.
- S=3, H=2, `data_in`=2'b10: strobe rises at E0+4, falls at E0+7, `done` is one cycle.
- `start` asserted throughout a launch with `data_in` changing: ignored until the `done` cycle, then accepted back-to-back with the new `data_in`.
- S=H=15 (CW=4): no wrap, strobe rises at E0+16, falls at E0+32.
- `rst_n` pulsed low while in HOLD: `strb_out`, `d_out` and `ready` return to reset values immediately, and no `done` is produced.
- With `SETUP_LAUNCH_NOTIFIER_EN` and `MIN_SETUP`=2:
  - S=1 toggles `notifier` 0→1;
  - S=2 leaves it unchanged;
  - without the macro, `notifier` stays 0.
